// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions for the MIPS32 five-stage core.
// Action encoding matches the last_act port values.
package pipe_pkg;
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_FLUSH  = 2'd3
  } act_e;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EXE = 2;
  localparam int STG_MEM = 3;

  localparam logic [7:0] NOP_ALUOP   = 8'h16;
  localparam logic [4:0] EXC_DEFAULT = 5'h10;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (inc && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: decodes load/hold/bubble/flush from the
// global stall vector and flush, with protocol-error flag and perf counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 128,
  parameter int                STALL_W    = 4,
  parameter int                STAGE_IDX  = 2,
  parameter logic [DATA_W-1:0] KEEP_MASK  = '0,
  parameter logic [DATA_W-1:0] RESET_VAL  = '0,
  parameter logic [DATA_W-1:0] FLUSH_VAL  = '0,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  input  logic               cnt_clr,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic [1:0]         last_act,
  output logic               stall_err,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);
  logic              own, dn, err_set;
  logic              stall_unused;
  act_e              act_d, act_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic              valid_d, valid_q, err_q;

  // Only two bits of the stall vector matter to this stage.
  assign stall_unused = ^stall;
  assign own          = stall[STAGE_IDX];

  generate
    if (STAGE_IDX + 1 < STALL_W) begin : g_dn
      assign dn = stall[STAGE_IDX+1];
    end else begin : g_last
      assign dn = 1'b0;
    end
  endgenerate

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    act_d   = ACT_LOAD;
    if (flush) begin
      act_d   = ACT_FLUSH;
      data_d  = FLUSH_VAL;
      valid_d = 1'b0;
    end else if (own && dn) begin
      act_d   = ACT_HOLD;
    end else if (own) begin
      act_d   = ACT_BUBBLE;
      data_d  = (in_data & KEEP_MASK) | (BUBBLE_VAL & ~KEEP_MASK);
      valid_d = 1'b0;
    end else begin
      data_d  = in_data;
      valid_d = in_valid;
    end
  end

  // Downstream stalled while we are not: stall vector is non-monotonic.
  assign err_set = !flush && !own && dn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
      act_q   <= ACT_LOAD;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      act_q   <= act_d;
      err_q   <= err_q | err_set;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .inc (act_d == ACT_HOLD),
    .clr (cnt_clr),
    .cnt (hold_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (act_d == ACT_BUBBLE),
    .clr (cnt_clr),
    .cnt (bubble_cnt)
  );

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign last_act  = act_q;
  assign stall_err = err_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised self-checking bench: three pipe_stage_reg configurations driven
// in parallel against a cycle-level behavioural model.
module tb_pipe_stage_reg;
  localparam int DW = 64;
  localparam int SW = 4;
  localparam logic [DW-1:0] KEEP_A = 64'h0000_001F_0000_0000;
  localparam logic [DW-1:0] BVAL_A = 64'hDEAD_BEEF_0000_0016;
  localparam logic [DW-1:0] RVAL_A = 64'h0000_0000_0000_00A5;
  localparam logic [DW-1:0] FVAL_A = 64'h0000_0000_0000_F1F1;
  localparam logic [DW-1:0] ZERO   = 64'h0;

  typedef struct {
    logic [DW-1:0] d;
    logic          v;
    int            act;
    logic          err;
    int            hc;
    int            bc;
  } mstate_t;

  logic          clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, cnt_clr = 1'b0;
  logic [SW-1:0] stall = '0;
  logic [DW-1:0] in_data = '0;

  logic [DW-1:0] oa_d, ob_d, oc_d;
  logic          oa_v, ob_v, oc_v, oa_e, ob_e, oc_e;
  logic [1:0]    oa_a, ob_a, oc_a;
  logic [15:0]   oa_h, oa_b;
  logic [1:0]    ob_h, ob_b, oc_h, oc_b;

  mstate_t ma, mb, mc;
  int n_cmp = 0, n_bad = 0;

  // A: EXE register with keep mask; B: last stage, small counters; C: EXE, small counters
  pipe_stage_reg #(.DATA_W(DW), .STALL_W(SW), .STAGE_IDX(2), .KEEP_MASK(KEEP_A),
    .RESET_VAL(RVAL_A), .FLUSH_VAL(FVAL_A), .BUBBLE_VAL(BVAL_A), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .cnt_clr(cnt_clr), .out_data(oa_d), .out_valid(oa_v),
    .last_act(oa_a), .stall_err(oa_e), .hold_cnt(oa_h), .bubble_cnt(oa_b));

  pipe_stage_reg #(.DATA_W(DW), .STALL_W(SW), .STAGE_IDX(3), .KEEP_MASK(ZERO),
    .RESET_VAL(ZERO), .FLUSH_VAL(ZERO), .BUBBLE_VAL(ZERO), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .cnt_clr(cnt_clr), .out_data(ob_d), .out_valid(ob_v),
    .last_act(ob_a), .stall_err(ob_e), .hold_cnt(ob_h), .bubble_cnt(ob_b));

  pipe_stage_reg #(.DATA_W(DW), .STALL_W(SW), .STAGE_IDX(2), .KEEP_MASK(ZERO),
    .RESET_VAL(ZERO), .FLUSH_VAL(ZERO), .BUBBLE_VAL(ZERO), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .cnt_clr(cnt_clr), .out_data(oc_d), .out_valid(oc_v),
    .last_act(oc_a), .stall_err(oc_e), .hold_cnt(oc_h), .bubble_cnt(oc_b));

  always #5 clk = ~clk;

  function automatic mstate_t mreset(logic [DW-1:0] rv);
    mstate_t s;
    s.d = rv; s.v = 1'b0; s.act = 0; s.err = 1'b0; s.hc = 0; s.bc = 0;
    return s;
  endfunction

  // One clock edge of the behavioural model, straight from the action table.
  function automatic mstate_t mstep(mstate_t s, int sidx, int cmax, logic [DW-1:0] keep,
                                    logic [DW-1:0] bval, logic [DW-1:0] fval);
    mstate_t n = s;
    bit own = stall[sidx];
    bit dn  = (sidx + 1 < SW) ? stall[(sidx+1)%SW] : 1'b0;
    if (flush) begin
      n.d = fval; n.v = 1'b0; n.act = 3;
    end else if (own && dn) begin
      n.act = 1; n.hc = (s.hc < cmax) ? s.hc + 1 : cmax;
    end else if (own) begin
      n.d = (in_data & keep) | (bval & ~keep); n.v = 1'b0; n.act = 2;
      n.bc = (s.bc < cmax) ? s.bc + 1 : cmax;
    end else begin
      n.d = in_data; n.v = in_valid; n.act = 0;
      if (dn) n.err = 1'b1;
    end
    if (cnt_clr) begin n.hc = 0; n.bc = 0; end
    return n;
  endfunction

  function automatic logic [99:0] pack(mstate_t s);
    return {s.d, s.v, 2'(s.act), s.err, 16'(s.hc), 16'(s.bc)};
  endfunction

  // Advance one edge (DUT and model), then settle 1ns past the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      ma = mreset(RVAL_A); mb = mreset(ZERO); mc = mreset(ZERO);
    end else begin
      ma = mstep(ma, 2, 65535, KEEP_A, BVAL_A, FVAL_A);
      mb = mstep(mb, 3, 3, ZERO, ZERO, ZERO);
      mc = mstep(mc, 2, 3, ZERO, ZERO, ZERO);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({oa_d, oa_v, oa_a, oa_e, oa_h, oa_b} !== pack(ma))
      begin n_bad++; $display("FAIL reset_a: got %h want %h", {oa_d, oa_v, oa_a, oa_e, oa_h, oa_b}, pack(ma)); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({oc_d, oc_v, oc_a, oc_e, 16'(oc_h), 16'(oc_b)} !== pack(mc))
      begin n_bad++; $display("FAIL reset_release_c: got %h want %h", {oc_d, oc_v, oc_a, oc_e, 16'(oc_h), 16'(oc_b)}, pack(mc)); end
  endtask

  task automatic test_load_hold();
    stall = 4'b0000; in_data = {$urandom, $urandom} & ~64'hFF | 64'hAB; in_valid = 1'b1;
    tick();
    n_cmp++;
    if ({oa_d, oa_v} !== {ma.d, 1'b1} || oa_d[7:0] !== 8'hAB)
      begin n_bad++; $display("FAIL load_a: got %h/%b want %h/1", oa_d, oa_v, ma.d); end
    stall = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      in_data = {$urandom, $urandom};
      tick();
      n_cmp++;
      if ({oa_d, oa_v, oa_a, oa_e, oa_h, oa_b} !== pack(ma))
        begin n_bad++; $display("FAIL hold_a[%0d]: got %h want %h", i, {oa_d, oa_v, oa_a, oa_e, oa_h, oa_b}, pack(ma)); end
    end
    n_cmp++;
    if (oa_h !== 16'd3 || oa_a !== 2'd1)
      begin n_bad++; $display("FAIL hold_cnt_a: got %0d/%0d want 3/1", oa_h, oa_a); end
  endtask

  task automatic test_bubble();
    stall = 4'b0100; in_valid = 1'b1;
    in_data = {$urandom, $urandom};
    in_data[36:32] = 5'h08;
    tick();
    n_cmp++;
    if (oa_d[36:32] !== 5'h08 || oa_d[7:0] !== 8'h16 || oa_v !== 1'b0 || oa_b !== 16'd1)
      begin n_bad++; $display("FAIL bubble_a: got %h v=%b bc=%0d want keep=08 low=16 v=0 bc=1", oa_d, oa_v, oa_b); end
    n_cmp++;
    if ({oa_d, oa_v, oa_a, oa_e, oa_h, oa_b} !== pack(ma))
      begin n_bad++; $display("FAIL bubble_model_a: got %h want %h", {oa_d, oa_v, oa_a, oa_e, oa_h, oa_b}, pack(ma)); end
  endtask

  task automatic test_flush();
    stall = 4'b1100; flush = 1'b1; in_data = {$urandom, $urandom};
    tick();
    flush = 1'b0;
    n_cmp++;
    if ({oa_d, oa_v, oa_a, oa_e, oa_h, oa_b} !== pack(ma) || oa_a !== 2'd3 || oa_d !== FVAL_A)
      begin n_bad++; $display("FAIL flush_a: got %h want %h", {oa_d, oa_v, oa_a, oa_e, oa_h, oa_b}, pack(ma)); end
    n_cmp++;
    if ({ob_d, ob_v, ob_a, ob_e, 16'(ob_h), 16'(ob_b)} !== pack(mb))
      begin n_bad++; $display("FAIL flush_b: got %h want %h", {ob_d, ob_v, ob_a, ob_e, 16'(ob_h), 16'(ob_b)}, pack(mb)); end
    stall = 4'b0000; in_data = {$urandom, $urandom}; in_valid = 1'b1;
    tick();
    n_cmp++;
    if ({oa_d, oa_v, oa_a, oa_e, oa_h, oa_b} !== pack(ma))
      begin n_bad++; $display("FAIL after_flush_a: got %h want %h", {oa_d, oa_v, oa_a, oa_e, oa_h, oa_b}, pack(ma)); end
  endtask

  task automatic test_proto_err();
    stall = 4'b1000; in_data = {$urandom, $urandom};
    tick();
    n_cmp++;
    if (oa_e !== 1'b1 || oa_a !== 2'd0 || oa_d !== in_data)
      begin n_bad++; $display("FAIL proto_err_a: got err=%b act=%0d want err=1 act=0", oa_e, oa_a); end
    n_cmp++;
    if ({ob_d, ob_v, ob_a, ob_e, 16'(ob_h), 16'(ob_b)} !== pack(mb))
      begin n_bad++; $display("FAIL proto_err_b: got %h want %h", {ob_d, ob_v, ob_a, ob_e, 16'(ob_h), 16'(ob_b)}, pack(mb)); end
    stall = 4'b0000;
    repeat (2) tick();
    n_cmp++;
    if (oa_e !== ma.err || oa_e !== 1'b1)
      begin n_bad++; $display("FAIL proto_err_sticky_a: got %b want 1", oa_e); end
    rst = 1'b1; #1;
    ma = mreset(RVAL_A); mb = mreset(ZERO); mc = mreset(ZERO);
    n_cmp++;
    if (oa_e !== 1'b0) begin n_bad++; $display("FAIL proto_err_rst_a: got %b want 0", oa_e); end
    rst = 1'b0;
  endtask

  task automatic test_sat_clr();
    stall = 4'b1100;
    repeat (5) tick();
    n_cmp++;
    if (oc_h !== 2'd3 || ob_b !== 2'd3)
      begin n_bad++; $display("FAIL sat_c_b: got hc=%0d bc=%0d want 3/3", oc_h, ob_b); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    n_cmp++;
    if ({oc_d, oc_v, oc_a, oc_e, 16'(oc_h), 16'(oc_b)} !== pack(mc) || oc_h !== 2'd0)
      begin n_bad++; $display("FAIL clr_c: got %h want %h", {oc_d, oc_v, oc_a, oc_e, 16'(oc_h), 16'(oc_b)}, pack(mc)); end
  endtask

  task automatic test_reset_mid_hold();
    stall = 4'b0000; in_data = {$urandom, $urandom}; in_valid = 1'b1;
    tick();
    stall = 4'b1100;
    tick();
    #2 rst = 1'b1; #1;
    ma = mreset(RVAL_A); mb = mreset(ZERO); mc = mreset(ZERO);
    n_cmp++;
    if ({oa_d, oa_v, oa_a, oa_e, oa_h, oa_b} !== pack(ma))
      begin n_bad++; $display("FAIL async_rst_a: got %h want %h", {oa_d, oa_v, oa_a, oa_e, oa_h, oa_b}, pack(ma)); end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall    = 4'($urandom);
      flush    = ($urandom_range(0, 9) == 0);
      cnt_clr  = ($urandom_range(0, 19) == 0);
      in_valid = 1'($urandom);
      in_data  = {$urandom, $urandom};
      tick();
      n_cmp++;
      if ({oa_d, oa_v, oa_a, oa_e, oa_h, oa_b} !== pack(ma))
        begin n_bad++; $display("FAIL rand_a[%0d]: got %h want %h", i, {oa_d, oa_v, oa_a, oa_e, oa_h, oa_b}, pack(ma)); end
      n_cmp++;
      if ({ob_d, ob_v, ob_a, ob_e, 16'(ob_h), 16'(ob_b)} !== pack(mb))
        begin n_bad++; $display("FAIL rand_b[%0d]: got %h want %h", i, {ob_d, ob_v, ob_a, ob_e, 16'(ob_h), 16'(ob_b)}, pack(mb)); end
      n_cmp++;
      if ({oc_d, oc_v, oc_a, oc_e, 16'(oc_h), 16'(oc_b)} !== pack(mc))
        begin n_bad++; $display("FAIL rand_c[%0d]: got %h want %h", i, {oc_d, oc_v, oc_a, oc_e, 16'(oc_h), 16'(oc_b)}, pack(mc)); end
    end
    flush = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    ma = mreset(RVAL_A); mb = mreset(ZERO); mc = mreset(ZERO);
    test_reset();
    test_load_hold();
    test_bubble();
    test_flush();
    test_proto_err();
    test_sat_clr();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the MIPS32 five-stage core. It is the generic replacement for the hand-written per-stage registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It carries an arbitrary-width payload plus a valid bit and decodes its own load, hold, bubble and flush actions from the global stall vector and flush. It adds the following over the fixed per-stage registers:
- synchronous flush
- per-bit pass-through of exception/PC fields during bubbles
- a stall-protocol error flag
- saturating hold/bubble performance counters

## Interface
Parameters:
- DATA_W, 128, payload width in bits
- STALL_W, 4, width of the global stall vector
- STAGE_IDX, 2, index of this register's stall bit; the downstream bit is STAGE_IDX+1
- KEEP_MASK, all-zero, bits set pass in_data through during a bubble (pc, in_delay, exccode, cp0_addr)
- RESET_VAL, all-zero, payload value on reset
- FLUSH_VAL, all-zero, payload value on flush
- BUBBLE_VAL, all-zero, payload value on non-KEEP bits during a bubble (e.g. aluop = NOP encoding)
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  STALL_W  global stall vector; bit i = stage i stalled
- flush  in  1  exception flush; sampled synchronously
- in_data  in  DATA_W  payload from upstream stage
- in_valid  in  1  upstream payload is a real instruction
- cnt_clr  in  1  synchronous clear of both counters
- out_data  out  DATA_W  registered payload to downstream stage
- out_valid  out  1  registered valid
- last_act  out  2  action taken at last edge: 0 LOAD, 1 HOLD, 2 BUBBLE, 3 FLUSH
- stall_err  out  1  sticky protocol-violation flag
- hold_cnt  out  CNT_W  saturating count of HOLD cycles
- bubble_cnt  out  CNT_W  saturating count of BUBBLE cycles

## Operation
- own = stall[STAGE_IDX]. dn = stall[STAGE_IDX+1] when STAGE_IDX+1 < STALL_W, else 0.
- Action priority, evaluated each rising edge:
  1. FLUSH: when flush=1. out_data←FLUSH_VAL, out_valid←0.
  2. BUBBLE: when own=1, dn=0. out_data←(in_data & KEEP_MASK) | (BUBBLE_VAL & ~KEEP_MASK), out_valid←0.
  3. HOLD: when own=1, dn=1. All outputs keep their values.
  4. LOAD: when own=0. out_data←in_data, out_valid←in_valid.
- last_act ← the action taken.
- Protocol error: own=0 with dn=1 (non-monotonic stall) when flush=0. The action is still LOAD, and stall_err is set to 1. stall_err clears only on rst.
- Counters:
  - hold_cnt increments on HOLD and bubble_cnt increments on BUBBLE.
  - Both saturate at 2^CNT_W−1 and do not wrap.
  - cnt_clr=1 zeroes both counters and takes priority over an increment in the same cycle.
  - Counters count only; they do not affect the datapath.
- flush during HOLD or BUBBLE conditions: FLUSH wins, and neither counter increments.

## Timing
- Reset (async assert, out of reset on the first edge after deassert):
  - out_data=RESET_VAL, out_valid=0, last_act=0
  - stall_err=0, hold_cnt=0, bubble_cnt=0
- Latency: one cycle, in_data → out_data.
- No combinational path from any input to any output.
- flush is synchronous. A one-cycle flush pulse affects exactly one edge.
- Reset asserted mid-HOLD discards held contents immediately, without waiting for a clock edge.
- STAGE_IDX = STALL_W−1: dn is tied to 0, so own=1 always bubbles and never holds.

## Structure
- Shared package pipe_pkg holds:
  - action enum (ACT_LOAD/HOLD/BUBBLE/FLUSH)
  - stage index constants STG_IF=0, STG_ID=1, STG_EXE=2, STG_MEM=3
  - NOP aluop constant 8'h16
  - default exccode 5'h10
- One natural sub-module: sat_counter (CNT_W, inc, clr), instantiated twice.
- The action decode and payload register stay in this module.

## Test plan
- Reset: hold rst=1 with clk running, then release → out_data=0, out_valid=0, counters 0. Assert rst mid-cycle → outputs 0 before the next edge.
- LOAD then HOLD, with STAGE_IDX=2: in_data=0x..AB, in_valid=1, stall=0000 → next edge out_data=0x..AB, out_valid=1. Then stall=1100 for 3 cycles with in_data changing → out_data stays 0x..AB, hold_cnt=3, last_act=1.
- BUBBLE with KEEP_MASK covering bits [36:32]: KEEP_MASK=bits[36:32], BUBBLE_VAL low byte 0x16, in_data bits[36:32]=5'h08, stall=0100 → out_data[36:32]=5'h08, out_data[7:0]=0x16, out_valid=0, bubble_cnt=1.
- Flush priority: stall=1100 plus flush=1 for one cycle → out_data=FLUSH_VAL, out_valid=0, last_act=3, hold_cnt unchanged. Next cycle stall=0000 loads normally.
- Protocol error: stall=1000 → LOAD occurs and stall_err=1. stall_err remains 1 after stall=0000, and clears only with rst.
- Counter saturation and clear, with CNT_W=2: 5 consecutive HOLD cycles → hold_cnt=3. cnt_clr=1 during a HOLD cycle → hold_cnt=0 on that edge.
